// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared constants and types for the next-PC unit
// Purpose: opcode/funct/REGIMM-rt encodings, FSM state enum and default
//          PC parameters shared by npc_pipe, br_resolve and npc_pipe_if.
// Ports:   none (package).
package npc_pkg;

  localparam int          PC_W_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } npc_state_e;

endpackage

// File: rtl/npc_pipe_if.sv
// rtl/npc_pipe_if.sv - ID / commit / fetch signal bundle for npc_pipe
// Purpose: groups the ID-stage inputs, commit redirects and fetch-side
//          outputs of the next-PC unit.
// Ports:   master drives if_hold, id_*, rs_val, rt_val, exc_req, eret_req,
//          epc and receives pc_if, link_pc, br_taken, flush_if, fetch_adel;
//          slave is the mirror image (used by npc_pipe).
interface npc_pipe_if
  import npc_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
);
  logic            if_hold;
  logic            id_stall;
  logic            id_valid;
  logic [31:0]     id_instr;
  logic [PC_W-1:0] id_pc;
  logic [31:0]     rs_val;
  logic [31:0]     rt_val;
  logic            exc_req;
  logic            eret_req;
  logic [PC_W-1:0] epc;
  logic [PC_W-1:0] pc_if;
  logic [PC_W-1:0] link_pc;
  logic            br_taken;
  logic            flush_if;
  logic            fetch_adel;

  modport master (
    output if_hold, id_stall, id_valid, id_instr, id_pc, rs_val, rt_val,
           exc_req, eret_req, epc,
    input  pc_if, link_pc, br_taken, flush_if, fetch_adel
  );

  modport slave (
    input  if_hold, id_stall, id_valid, id_instr, id_pc, rs_val, rt_val,
           exc_req, eret_req, epc,
    output pc_if, link_pc, br_taken, flush_if, fetch_adel
  );
endinterface

// File: rtl/npc_pipe_br_resolve.sv
// rtl/npc_pipe_br_resolve.sv - combinational branch/jump decode and target
// Purpose: decodes the ID instruction, evaluates the branch condition on the
//          forwarded operands and forms the transfer target.
// Ports:   instr, pc (ID instruction and its PC), rs, rt (forwarded operands)
//          in; is_xfer (instruction is a branch/jump), taken (jump, or
//          branch with true condition), target out.
module br_resolve
  import npc_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc,
  input  logic [31:0]     rs,
  input  logic [31:0]     rt,
  output logic            is_xfer,
  output logic            taken,
  output logic [PC_W-1:0] target
);

  logic [5:0]      op;
  logic [5:0]      fn;
  logic [4:0]      rtf;
  logic [15:0]     imm;
  logic            rs_zero;
  logic            rs_neg;
  logic            eq;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] j_tgt;

  assign op      = instr[31:26];
  assign fn      = instr[5:0];
  assign rtf     = instr[20:16];
  assign imm     = instr[15:0];
  assign rs_zero = (rs == 32'd0);
  assign rs_neg  = rs[31];
  assign eq      = (rs == rt);

  // Sum is taken at PC_W bits so the target wraps modulo 2^PC_W.
  assign br_tgt = pc + PC_W'(4) + {{(PC_W-18){imm[15]}}, imm, 2'b00};

  always_comb begin
    // Upper PC bits of the ID instruction are kept, low 28 come from index.
    j_tgt        = pc;
    j_tgt[27:0]  = {instr[25:0], 2'b00};
    is_xfer      = 1'b0;
    taken        = 1'b0;
    target       = br_tgt;
    case (op)
      OP_BEQ:  begin is_xfer = 1'b1; taken = eq;                 end
      OP_BNE:  begin is_xfer = 1'b1; taken = ~eq;                end
      OP_BLEZ: begin is_xfer = 1'b1; taken = rs_neg | rs_zero;   end
      OP_BGTZ: begin is_xfer = 1'b1; taken = ~rs_neg & ~rs_zero; end
      OP_REGIMM: begin
        if (rtf == RT_BLTZ) begin
          is_xfer = 1'b1;
          taken   = rs_neg;
        end else if (rtf == RT_BGEZ) begin
          is_xfer = 1'b1;
          taken   = ~rs_neg;
        end
      end
      OP_J, OP_JAL: begin
        is_xfer = 1'b1;
        taken   = 1'b1;
        target  = j_tgt;
      end
      OP_SPECIAL: begin
        if (fn == FN_JR || fn == FN_JALR) begin
          is_xfer = 1'b1;
          taken   = 1'b1;
          target  = rs[PC_W-1:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/npc_pipe.sv
// rtl/npc_pipe.sv - registered fetch-address unit with redirect buffering
// Purpose: holds pc_if, arbitrates exception/eret/pending/ID-transfer/
//          sequential sources and buffers an ID transfer that resolves while
//          fetch is held.
// Ports:   clk, reset (sync, active-high); bus (npc_pipe_if.slave) carrying
//          if_hold, id_* inputs, operands, exc/eret commit and epc in, and
//          pc_if, link_pc, br_taken, flush_if, fetch_adel out.
module npc_pipe
  import npc_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(RESET_PC_DEF),
  parameter logic [PC_W-1:0] EXC_PC     = PC_W'(EXC_PC_DEF),
  parameter bit              DELAY_SLOT = 1'b1
) (
  input logic       clk,
  input logic       reset,
  npc_pipe_if.slave bus
);

  logic            br_xfer;
  logic            br_cond;
  logic [PC_W-1:0] br_target;
  logic            take;
  npc_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_q, pend_d;

  br_resolve #(.PC_W(PC_W)) u_br (
    .instr   (bus.id_instr),
    .pc      (bus.id_pc),
    .rs      (bus.rs_val),
    .rt      (bus.rt_val),
    .is_xfer (br_xfer),
    .taken   (br_cond),
    .target  (br_target)
  );

  assign take         = bus.id_valid & ~bus.id_stall & br_xfer & br_cond;
  assign bus.br_taken = take;
  assign bus.link_pc  = bus.id_pc + PC_W'(8);
  // With a delay slot the IF instruction is architecturally executed, so
  // only commit redirects kill it.
  assign bus.flush_if = bus.exc_req | bus.eret_req | (!DELAY_SLOT & take);
  assign bus.pc_if      = pc_q;
  assign bus.fetch_adel = |pc_q[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    if (bus.exc_req) begin
      // Commit redirects override holds, stalls and any buffered target;
      // a coincident ID transfer is simply dropped.
      pc_d    = EXC_PC;
      pend_d  = '0;
      state_d = ST_RUN;
    end else if (bus.eret_req) begin
      pc_d    = bus.epc;
      pend_d  = '0;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!bus.if_hold) begin
            if (take)               pc_d = br_target;
            else if (!bus.id_stall) pc_d = pc_q + PC_W'(4);
          end else if (take) begin
            pend_d  = br_target;
            state_d = ST_PEND;
          end
        end
        ST_PEND: begin
          // An ID stall keeps the buffered target until ID moves again.
          if (!bus.if_hold && !bus.id_stall) begin
            pc_d    = pend_q;
            pend_d  = '0;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_npc_pipe.sv
// tb/tb_npc_pipe.sv - scoreboard bench for npc_pipe
// Purpose: drives directed ID/commit vectors into two npc_pipe copies
//          (DELAY_SLOT 0 and 1) and checks outputs against queued
//          hand-computed expectations.
// Ports:   none (top-level bench).
module tb_npc_pipe;
  import npc_pkg::*;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    bit          tk;
    bit          fl0;
    bit          fl1;
    logic [31:0] link;
    bit          chk_st;
    npc_state_e  st;
    bit          chk_pd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  npc_pipe_if #(.PC_W(32)) if0 ();
  npc_pipe_if #(.PC_W(32)) if1 ();

  assign if1.if_hold  = if0.if_hold;
  assign if1.id_stall = if0.id_stall;
  assign if1.id_valid = if0.id_valid;
  assign if1.id_instr = if0.id_instr;
  assign if1.id_pc    = if0.id_pc;
  assign if1.rs_val   = if0.rs_val;
  assign if1.rt_val   = if0.rt_val;
  assign if1.exc_req  = if0.exc_req;
  assign if1.eret_req = if0.eret_req;
  assign if1.epc      = if0.epc;

  npc_pipe #(.PC_W(32), .DELAY_SLOT(1'b0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));
  npc_pipe #(.PC_W(32), .DELAY_SLOT(1'b1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares away from the edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.nm, ".pc_if0"},   if0.pc_if, e.pc);
      chk({e.nm, ".pc_if1"},   if1.pc_if, e.pc);
      chk({e.nm, ".br_taken"}, 32'(if0.br_taken), 32'(e.tk));
      chk({e.nm, ".flush_ds0"}, 32'(if0.flush_if), 32'(e.fl0));
      chk({e.nm, ".flush_ds1"}, 32'(if1.flush_if), 32'(e.fl1));
      chk({e.nm, ".link_pc"},  if0.link_pc, e.link);
      chk({e.nm, ".adel"},     32'(if0.fetch_adel), 32'(|e.pc[1:0]));
      if (e.chk_st) chk({e.nm, ".state"}, 32'(u0.state_q), 32'(e.st));
      if (e.chk_pd) chk({e.nm, ".pend"},  u0.pend_q, 32'h0);
    end
  end

  task automatic id(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                    input logic [31:0] rs, input logic [31:0] rt);
    if0.id_valid = v;
    if0.id_instr = instr;
    if0.id_pc    = pc;
    if0.rs_val   = rs;
    if0.rt_val   = rt;
  endtask

  task automatic ctl(input bit stall, input bit hold, input bit exc, input bit eret,
                     input logic [31:0] epc);
    if0.id_stall = stall;
    if0.if_hold  = hold;
    if0.exc_req  = exc;
    if0.eret_req = eret;
    if0.epc      = epc;
  endtask

  // Queue expectation for the current cycle, then advance to the next one.
  task automatic step(input string nm, input logic [31:0] pc, input bit tk,
                      input bit chk_st, input npc_state_e st, input bit chk_pd);
    exp_t e;
    e.nm     = nm;
    e.pc     = pc;
    e.tk     = tk;
    e.fl0    = tk | if0.exc_req | if0.eret_req;
    e.fl1    = if0.exc_req | if0.eret_req;
    e.link   = if0.id_pc + 32'd8;
    e.chk_st = chk_st;
    e.st     = st;
    e.chk_pd = chk_pd;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    id(0, 0, 0, 0, 0);
    ctl(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    step("reset", 32'h3000, 0, 1, ST_RUN, 1);
    step("seq1",  32'h3004, 0, 0, ST_RUN, 0);
    step("seq2",  32'h3008, 0, 0, ST_RUN, 0);
    id(1, 32'h1022FFFC, 32'h3010, 5, 5);
    step("beq_t", 32'h300C, 1, 0, ST_RUN, 0);
    id(1, 32'h1022FFFC, 32'h3010, 5, 6);
    step("beq_n", 32'h3004, 0, 0, ST_RUN, 0);
    id(1, 32'h0020F809, 32'h3020, 32'h3400, 0);
    step("jalr",  32'h3008, 1, 0, ST_RUN, 0);
    id(0, 0, 0, 0, 0);
    step("jalr_tgt", 32'h3400, 0, 0, ST_RUN, 0);
    id(1, 32'h14220040, 32'h3404, 7, 7);
    step("bne_n", 32'h3404, 0, 0, ST_RUN, 0);
    id(1, 32'h18200002, 32'h3408, 0, 0);
    step("blez0", 32'h3408, 1, 0, ST_RUN, 0);
    id(1, 32'h1C200040, 32'h3414, 32'h8000_0000, 0);
    step("bgtz_neg", 32'h3414, 0, 0, ST_RUN, 0);
    id(1, 32'h0420FFFE, 32'h3418, 32'h8000_0000, 0);
    step("bltz_neg", 32'h3418, 1, 0, ST_RUN, 0);
    id(1, 32'h00221821, 32'h3414, 0, 0);
    step("addu", 32'h3414, 0, 0, ST_RUN, 0);
    id(1, 32'h1022FFFC, 32'h3010, 5, 5);
    ctl(1, 0, 0, 0, 0);
    step("stall", 32'h3418, 0, 0, ST_RUN, 0);
    id(0, 0, 0, 0, 0);
    ctl(0, 0, 0, 0, 0);
    step("stall_hold", 32'h3418, 0, 0, ST_RUN, 0);

    id(1, 32'h08000C40, 32'h3030, 0, 0);
    ctl(0, 1, 0, 0, 0);
    step("j_hold", 32'h341C, 1, 1, ST_RUN, 0);
    id(0, 0, 0, 0, 0);
    step("pend1", 32'h341C, 0, 1, ST_PEND, 0);
    step("pend2", 32'h341C, 0, 1, ST_PEND, 0);
    ctl(0, 0, 0, 0, 0);
    step("pend3", 32'h341C, 0, 1, ST_PEND, 0);
    step("pend_tgt", 32'h3100, 0, 1, ST_RUN, 0);

    id(1, 32'h08000C80, 32'h3100, 0, 0);
    ctl(0, 1, 0, 0, 0);
    step("j_hold2", 32'h3104, 1, 0, ST_RUN, 0);
    id(1, 32'h04210010, 32'h3050, 5, 0);
    ctl(0, 1, 1, 0, 0);
    step("exc_bgez", 32'h3104, 1, 1, ST_PEND, 0);
    id(0, 0, 0, 0, 0);
    ctl(0, 0, 0, 0, 0);
    step("exc_pc", 32'h4180, 0, 1, ST_RUN, 1);
    ctl(0, 0, 0, 1, 32'h3044);
    step("eret", 32'h4184, 0, 0, ST_RUN, 0);
    ctl(0, 0, 0, 0, 0);
    id(1, 32'h00200008, 32'h3044, 32'h3002, 0);
    step("jr", 32'h3044, 1, 0, ST_RUN, 0);
    id(0, 0, 0, 0, 0);
    step("adel1", 32'h3002, 0, 0, ST_RUN, 0);
    id(1, 32'h08000C40, 32'h3000, 0, 0);
    ctl(0, 1, 0, 0, 0);
    step("adel2", 32'h3006, 1, 0, ST_RUN, 0);
    id(0, 0, 0, 0, 0);
    reset = 1'b1;
    step("pend_rst", 32'h3006, 0, 1, ST_PEND, 0);
    reset = 1'b0;
    ctl(0, 0, 0, 0, 0);
    step("after_rst", 32'h3000, 0, 1, ST_RUN, 1);
    step("after_rst_seq", 32'h3004, 0, 0, ST_RUN, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/npc_pipe.md
# npc_pipe

Parametrised fetch-address unit for the five-stage pipeline. It replaces the combinational next-PC path with a registered PC and resolves, in ID, every branch and jump in the target instruction set. It arbitrates exception and eret redirects, and buffers a redirect that arrives while instruction fetch is held, so no control transfer is lost. It sits between ID (instruction, forwarded operands) and the instruction memory address port.

## Interface
- `PC_W`, 32: PC width (≥ 28, instr-index concatenation uses `PC[PC_W-1:28]`)
- `RESET_PC`, 32'h0000_3000: PC after reset
- `EXC_PC`, 32'h0000_4180: exception handler entry
- `DELAY_SLOT`, 1: 1 = MIPS delay slot executes; 0 = taken transfer flushes IF
- `clk  in  1`: single clock, all state updates on rising edge
- `reset  in  1`: synchronous, active-high
- `if_hold  in  1`: instruction memory not ready; PC must not advance
- `id_stall  in  1`: hazard stall; ID instruction held, PC must not advance
- `id_valid  in  1`: ID holds a real instruction
- `id_instr  in  32`: instruction in ID
- `id_pc  in  PC_W`: PC of the ID instruction
- `rs_val, rt_val  in  32`: forwarded GPR operands
- `exc_req  in  1`: exception commit, redirect to `EXC_PC`
- `eret_req  in  1`: eret commit, redirect to `epc`
- `epc  in  PC_W`: return address
- `pc_if  out  PC_W`: fetch address (registered)
- `link_pc  out  PC_W`: `id_pc + 8` for jal/jalr
- `br_taken  out  1`: ID transfer taken this cycle (combinational)
- `flush_if  out  1`: kill instruction in IF (combinational)
- `fetch_adel  out  1`: `pc_if[1:0] != 0`

## Operation
- Decoded in ID: beq, bne, blez, bgtz, bltz, bgez (REGIMM rt=00000/00001), j, jal, jr, jalr (SPECIAL funct 001000/001001). Anything else → not a transfer.
- Conditions: beq `rs==rt`; bne `rs!=rt`; blez `rs[31]|rs==0`; bgtz `!rs[31]&rs!=0`; bltz `rs[31]`; bgez `!rs[31]`. Compare is signed, on 32 bits.
- Targets:
  - branch: `id_pc+4+{sext(imm),2'b00}`, truncated to `PC_W` (wraps modulo 2^PC_W).
  - j/jal: `{id_pc[PC_W-1:28], index, 2'b00}`.
  - jr/jalr: `rs_val[PC_W-1:0]`, unaligned values passed unchanged.
- `br_taken` = `id_valid & !id_stall &` (jump, or branch with condition true).
- Redirect priority: `reset` > `exc_req` > `eret_req` > pending > ID taken > sequential `pc_if+4`.
  - Exception and eret redirects ignore `if_hold` and `id_stall`, and they clear any pending target.
- FSM:
  - **RUN**, entered on reset.
    - `if_hold=0`: `pc_if` ← highest-priority source.
    - `if_hold=1` and `br_taken`: latch target into `pend_pc` → PEND; `pc_if` holds.
    - `if_hold=1`, no transfer: hold.
  - **PEND**: `pc_if` holds while `if_hold=1`.
    - First cycle with `if_hold=0`: `pc_if` ← `pend_pc` → RUN.
    - `exc_req`/`eret_req`: redirect → RUN.
- With `id_stall=1` and no exception/eret, `pc_if` holds. Pending state is preserved.
- `DELAY_SLOT=0`: `flush_if = br_taken | exc_req | eret_req`. `DELAY_SLOT=1`: `flush_if = exc_req | eret_req`.

## Timing
- Reset: `pc_if=RESET_PC`, state RUN, `pend_pc=0`, `fetch_adel` follows `RESET_PC`.
- Redirect latency is 1 cycle: a taken transfer in ID at edge n gives `pc_if=target` after edge n.
- If `if_hold` is asserted, the target appears in `pc_if` one cycle after `if_hold` falls.
- `exc_req` and `br_taken` in the same cycle: `EXC_PC` wins and the branch is dropped.
- `reset` during PEND: pending is discarded and `pc_if=RESET_PC`.
- `link_pc`, `br_taken` and `flush_if` are combinational from ID inputs in the same cycle.

## Structure
- Shared package `npc_pkg`: opcode/funct/REGIMM-rt constants, the FSM state enum, and `PC_W`/`RESET_PC`/`EXC_PC` defaults.
- Sub-module `br_resolve`: purely combinational decode, compare and target. Outputs `is_xfer`, `taken`, `target`.
- The top level holds `pc_if`, `pend_pc`, the state register and the priority mux.

## Test plan
- Reset then free run, `PC_W=32`: `pc_if` = 0x3000, 0x3004, 0x3008; `fetch_adel=0`.
- beq at `id_pc`=0x3010, imm=0xFFFC, rs=rt=5: `br_taken=1`, next `pc_if`=0x3004. Repeat with rt=6: not taken, sequential.
- jalr with `rs_val`=0x3400 at `id_pc`=0x3020:
  - next `pc_if`=0x3400, `link_pc`=0x3028.
  - `DELAY_SLOT=0`: `flush_if=1`.
  - `DELAY_SLOT=1`: `flush_if=0`.
- j taken while `if_hold=1` for 3 cycles:
  - state PEND, `pc_if` frozen.
  - `pc_if` = target one cycle after `if_hold` drops.
  - then sequential +4.
- `exc_req` coincident with taken bgez in PEND: `pc_if`=0x4180, pending cleared. Later `eret_req` with `epc`=0x3044 gives `pc_if`=0x3044.
- jr to 0x3002: `fetch_adel=1` next cycle. `reset` asserted mid-PEND: `pc_if`=0x3000, state RUN.
